// File: rtl/sub16_serial.sv
// ---------------------------------------------------------------------------
// sub16_serial
//
// Bit-serial WIDTH-bit subtractor computing in1 - in2 with one full-adder
// slice that is reused over WIDTH cycles. It produces the same status flags
// as the parallel carry-lookahead adder (borrow, zero, parity, sign,
// overflow), so a controller can take flags from either unit.
//
// Optional feature macro: SUB16_ADDMODE_EN
//   When defined, an extra 'op' input selects add (op=1) or subtract (op=0).
//   In add mode 'borrow' reports the plain carry-out.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   request, honoured only in IDLE or DONE
//   op        in   (SUB16_ADDMODE_EN only) 1 = add, 0 = subtract
//   in1       in   minuend, captured on the accepting edge
//   in2       in   subtrahend, captured on the accepting edge
//   busy      out  high while the serial computation runs
//   done      out  one-cycle pulse, results valid from this cycle on
//   diff      out  in1 - in2 mod 2^WIDTH
//   borrow    out  1 when unsigned in1 < in2
//   parity    out  XOR of all diff bits
//   overflow  out  signed overflow of the operation
//   zero      out  diff == 0
//   sign      out  diff MSB
// ---------------------------------------------------------------------------
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SUB16_ADDMODE_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             parity,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] r_reg;
  logic             carry;
  logic [CW-1:0]    count;
  logic             a_msb;
  logic             b_msb;
`ifdef SUB16_ADDMODE_EN
  logic             op_reg;
`endif

  logic             accept;
  logic             last_slice;
  logic             slice_sum;
  logic             slice_carry;
  logic [WIDTH-1:0] result;
  logic             borrow_next;
  logic             overflow_next;

  // A new operation is taken only while not computing, so a start pulse
  // during RUN is simply dropped.
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_slice = (state == RUN) && (count == CW'(WIDTH - 1));

  // The single full-adder slice working on the current LSBs.
  assign slice_sum   = a_reg[0] ^ b_reg[0] ^ carry;
  assign slice_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

  // Sum bits enter at the top and drift down, so after the last slice the
  // earliest (least significant) sum bit sits at bit 0.
  assign result = {slice_sum, r_reg};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Flag selection at completion. Subtraction adds ~in2 + 1, so a missing
  // carry-out means a borrow; overflow uses the original in2 MSB.
  always_comb begin
    borrow_next   = ~slice_carry;
    overflow_next = (a_msb ^ b_msb) & (slice_sum ^ a_msb);
`ifdef SUB16_ADDMODE_EN
    if (op_reg) begin
      borrow_next   = slice_carry;
      overflow_next = ~(a_msb ^ b_msb) & (slice_sum ^ a_msb);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE falls back to IDLE unless a new request arrives,
  // which allows back-to-back operations without an idle cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: operand shift registers, carry, slice counter and the
  // registered result/flags, which only change on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      carry    <= 1'b0;
      count    <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
`ifdef SUB16_ADDMODE_EN
      op_reg   <= 1'b0;
`endif
      diff     <= '0;
      borrow   <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
    end else if (accept) begin
      a_reg <= in1;
      count <= '0;
      a_msb <= in1[WIDTH-1];
      b_msb <= in2[WIDTH-1];
`ifdef SUB16_ADDMODE_EN
      op_reg <= op;
      b_reg  <= op ? in2 : ~in2;
      carry  <= ~op;
`else
      b_reg <= ~in2;
      carry <= 1'b1;
`endif
    end else if (state == RUN) begin
      a_reg <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg <= {1'b0, b_reg[WIDTH-1:1]};
      r_reg <= result[WIDTH-1:1];
      carry <= slice_carry;
      count <= count + 1'b1;
      if (last_slice) begin
        diff     <= result;
        borrow   <= borrow_next;
        overflow <= overflow_next;
        parity   <= ^result;
        zero     <= (result == '0);
        sign     <= result[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// ---------------------------------------------------------------------------
// tb_sub16_serial
//
// Directed testbench for sub16_serial. Expected results come from a
// behavioural model of the subtraction and are queued when an operation is
// started, then popped and compared when done pulses. Timing of busy/done,
// back-to-back throughput, start-during-RUN and mid-run reset are covered.
// Define SUB16_ADDMODE_EN to also exercise the add mode.
// ---------------------------------------------------------------------------
module tb_sub16_serial;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        parity;
    logic        overflow;
    logic        zero;
    logic        sign;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
`ifdef SUB16_ADDMODE_EN
  logic        op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        parity;
  logic        overflow;
  logic        zero;
  logic        sign;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cycle_count = 0;
  int   accept_cycle = 0;
  int   first_done = 0;
  logic saw_done;

  sub16_serial #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef SUB16_ADDMODE_EN
    .op       (op),
`endif
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .parity   (parity),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Behavioural reference: plain arithmetic on the full operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic add_op);
    exp_t        e;
    logic [16:0] full;
    if (add_op) begin
      full       = {1'b0, a} + {1'b0, b};
      e.diff     = full[15:0];
      e.borrow   = full[16];
      e.overflow = (a[15] == b[15]) && (e.diff[15] != a[15]);
    end else begin
      e.diff     = a - b;
      e.borrow   = (a < b);
      e.overflow = (a[15] != b[15]) && (e.diff[15] != a[15]);
    end
    e.parity = ^e.diff;
    e.zero   = (e.diff == 16'h0000);
    e.sign   = e.diff[15];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle (caller sits on a negedge), queue
  // the expected result, then confirm the unit went busy.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic add_op);
    in1   = a;
    in2   = b;
    start = 1'b1;
`ifdef SUB16_ADDMODE_EN
    op    = add_op;
`endif
    sb.push_back(model(a, b, add_op));
    @(negedge clk);
    start        = 1'b0;
    accept_cycle = cycle_count;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("done_low_after_accept", {31'b0, done}, 32'd0);
  endtask

  // Wait (bounded) for done and check its latency relative to acceptance.
  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("done_latency", cycle_count - accept_cycle, 32'd16);
    check("busy_low_at_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic checkOutput();
    exp_t e;
    n_asserts++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("diff", {16'b0, diff}, {16'b0, e.diff});
      check("borrow", {31'b0, borrow}, {31'b0, e.borrow});
      check("parity", {31'b0, parity}, {31'b0, e.parity});
      check("overflow", {31'b0, overflow}, {31'b0, e.overflow});
      check("zero", {31'b0, zero}, {31'b0, e.zero});
      check("sign", {31'b0, sign}, {31'b0, e.sign});
    end
  endtask

  task automatic checkAllLow(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_diff"}, {16'b0, diff}, 32'd0);
    check({tag, "_flags"}, {27'b0, borrow, parity, overflow, zero, sign}, 32'd0);
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in1   = 16'h0000;
    in2   = 16'h0000;
`ifdef SUB16_ADDMODE_EN
    op    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkAllLow("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic subtract");
    applyStimulus(16'h8FFF, 16'h8000, 1'b0);
    waitDone(40);
    checkOutput();
    @(negedge clk);
    check("done_single_cycle", {31'b0, done}, 32'd0);
    check("idle_not_busy", {31'b0, busy}, 32'd0);

    $display("[TB] borrow");
    applyStimulus(16'h0002, 16'h0003, 1'b0);
    waitDone(40);
    checkOutput();

    $display("[TB] signed overflow");
    @(negedge clk);
    applyStimulus(16'h8000, 16'h0001, 1'b0);
    waitDone(40);
    checkOutput();

    $display("[TB] zero, start during RUN, back-to-back");
    @(negedge clk);
    applyStimulus(16'hAAAA, 16'hAAAA, 1'b0);
    repeat (4) @(negedge clk);
    in1   = 16'h1234;
    in2   = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignores_start", {31'b0, busy}, 32'd1);
    waitDone(40);
    checkOutput();
    first_done = cycle_count;
    applyStimulus(16'h0005, 16'h0003, 1'b0);
    waitDone(40);
    check("back_to_back_spacing", cycle_count - first_done, 32'd17);
    checkOutput();

    $display("[TB] reset mid-operation");
    @(negedge clk);
    applyStimulus(16'h1111, 16'h0101, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAllLow("mid_reset");
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_reset", {31'b0, saw_done}, 32'd0);
    applyStimulus(16'h0007, 16'h0009, 1'b0);
    waitDone(40);
    checkOutput();

`ifdef SUB16_ADDMODE_EN
    $display("[TB] add mode");
    @(negedge clk);
    applyStimulus(16'hFFFE, 16'h0002, 1'b1);
    waitDone(40);
    checkOutput();
    @(negedge clk);
    applyStimulus(16'h7FFF, 16'h0001, 1'b1);
    waitDone(40);
    checkOutput();
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sub16_serial.md
# sub16_serial

Bit-serial 16-bit subtractor (X − Y) with start/done handshake and the same status-flag set as the datapath's 16-bit carry-lookahead adder: borrow, zero, parity, sign, overflow. It runs one full-adder slice over WIDTH cycles, trading latency for area. It sits alongside the parallel adder as the subtract path in area-constrained ALU builds. Its flags are defined so a controller can consume either unit's flags interchangeably.

## Interface
- WIDTH, 16, operand and result width; also the number of compute cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when accepting (IDLE or DONE state).
- in1  in  WIDTH  minuend, captured on the accepting edge.
- in2  in  WIDTH  subtrahend, captured on the accepting edge.
- busy  out  1  high while computing.
- done  out  1  single-cycle pulse; result and flags valid from this cycle on.
- diff  out  WIDTH  result in1 − in2, mod 2^WIDTH.
- borrow  out  1  1 when unsigned in1 < in2.
- parity  out  1  XOR of all diff bits (1 = odd number of ones).
- overflow  out  1  signed overflow of the subtraction.
- zero  out  1  diff == 0.
- sign  out  1  diff[WIDTH-1].

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - load A=in1 and B=~in2 into shift registers;
  - set carry=1 and count=0;
  - move to RUN.
- DONE with start=0 moves to IDLE.
- RUN, each cycle:
  - s = A[0]^B[0]^carry; carry = majority(A[0],B[0],carry);
  - shift A and B right;
  - shift s into the MSB of working register R;
  - count++.
- When count reaches WIDTH−1 and that slice completes:
  - diff ← final R;
  - borrow ← ~carry_out;
  - overflow ← (in1 MSB != in2 MSB) && (diff MSB != in1 MSB), using the captured operand MSBs;
  - zero, sign, parity derived from the final diff;
  - move to DONE.
- diff and all flags are registered. They change only on the completion edge and hold until the next completion or reset.
- start during RUN is ignored. The in-flight operation is not disturbed and no request is queued.
- in1 and in2 are don't-care except on the accepting edge.

## Timing
- Reset (takes priority over everything, including mid-RUN):
  - state=IDLE;
  - busy, done, diff, borrow, parity, overflow, zero, sign all 0;
  - any in-flight operation is discarded and produces no done.
- Accepting edge E: busy=1 from the cycle after E.
- Completion edge: E+WIDTH (E+16 by default). In the cycle after it, done=1, busy=0, and outputs are valid.
- done stays high for exactly one cycle unless start is asserted during it.
- start=1 in the DONE cycle is accepted: back-to-back operations with throughput WIDTH+1 cycles. In that case busy=1 in the next cycle and done is not re-asserted until the new completion.
- busy and done are never high simultaneously.

## Configuration
- SUB16_ADDMODE_EN defined:
  - adds input op (1 bit), captured with the operands; op=1 selects add and op=0 selects subtract;
  - add loads B=in2 and carry=0;
  - borrow carries the carry-out (not inverted);
  - overflow = (in1 MSB == in2 MSB) && (diff MSB != in1 MSB).
- Not defined: op port absent; the unit always subtracts as described above.

## Test plan
- Basic subtract: in1=0x8FFF, in2=0x8000, start at edge E.
  - done in the cycle after E+16;
  - diff=0x0FFF, borrow=0, overflow=0, zero=0, sign=0, parity=0.
- Borrow: in1=0x0002, in2=0x0003.
  - diff=0xFFFF, borrow=1, sign=1, parity=0, overflow=0, zero=0.
- Signed overflow: in1=0x8000, in2=0x0001.
  - diff=0x7FFF, overflow=1, borrow=0, sign=0, parity=1.
- Zero, then busy-ignore and back-to-back:
  - 0xAAAA−0xAAAA → diff=0x0000, zero=1, borrow=0, parity=0.
  - start pulsed mid-RUN with 0x1234/0x0001 is ignored and the result is unchanged.
  - start in the DONE cycle with 0x0005−0x0003 → diff=0x0002 exactly 17 cycles after the first done.
- Reset mid-operation: assert rst 8 cycles into RUN.
  - All outputs 0 the next cycle;
  - no done pulse follows;
  - a new start completes normally.
- With SUB16_ADDMODE_EN: op=1, in1=0xFFFE, in2=0x0002.
  - diff=0x0000, borrow=1, zero=1, overflow=0.
